pipe_stage_reg: RTL and testbench

Generic parametrised pipeline stage register that supersedes the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control bundle and a data bundle with a valid/ready handshake, synchronous flush (bubble insertion) and an optional skid entry that registers the upstream ready path. Control bits are forced to zero on bubbles, so a flushed or empty stage can never write the register file or memory.

---
 rtl/pipe_stage_reg.sv | 135 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, flush and optional skid entry.
// Optional PIPE_STAGE_PERF_EN adds stall_cnt/flush_cnt performance counters.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  entry_t     main_q, in_e;
  logic       up_xfer, dn_xfer;
  logic [1:0] held;

  assign in_e    = '{ctrl: in_ctrl, data: in_data};
  assign up_xfer = in_valid & in_ready;
  assign dn_xfer = out_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      state_t state_q, state_d;
      entry_t skid_q;
      logic   load_main_in, load_main_skid, load_skid;

      // in_ready decodes only the state flop, so no combinational path from out_ready
      assign in_ready  = (state_q != TWO);
      assign out_valid = (state_q != EMPTY);
      assign held      = (state_q == TWO) ? 2'd2 : (state_q == ONE) ? 2'd1 : 2'd0;

      always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
          state_d = EMPTY;
        end else begin
          case (state_q)
            EMPTY: if (up_xfer) begin
              state_d      = ONE;
              load_main_in = 1'b1;
            end
            ONE: begin
              if (up_xfer && dn_xfer) begin
                load_main_in = 1'b1;
              end else if (up_xfer) begin
                state_d   = TWO;
                load_skid = 1'b1;
              end else if (dn_xfer) begin
                state_d = EMPTY;
              end
            end
            TWO: if (dn_xfer) begin
              state_d        = ONE;
              load_main_skid = 1'b1;
            end
            default: state_d = EMPTY;
          endcase
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q <= EMPTY;
          main_q  <= '0;
          skid_q  <= '0;
        end else begin
          state_q <= state_d;
          if (load_main_in)        main_q <= in_e;
          else if (load_main_skid) main_q <= skid_q;
          if (load_skid)           skid_q <= in_e;
        end
      end
    end else begin : g_flat
      logic vld_q;

      assign in_ready  = ~vld_q | out_ready;
      assign out_valid = vld_q;
      assign held      = {1'b0, vld_q};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q  <= 1'b0;
          main_q <= '0;
        end else if (flush) begin
          vld_q <= 1'b0;
        end else if (up_xfer) begin
          vld_q  <= 1'b1;
          main_q <= in_e;
        end else if (dn_xfer) begin
          vld_q <= 1'b0;
        end
      end
    end
  endgenerate

  // Bubbles carry zero control so an empty stage cannot cause side effects
  assign out_ctrl = main_q.ctrl & {CTRL_W{out_valid}};
  assign out_data = main_q.data;

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready) stall_cnt <= stall_cnt + 32'd1;
      if (flush) flush_cnt <= flush_cnt + 32'(held) + 32'(up_xfer);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances checked against a queue model.
module tb_pipe_stage_reg;
  typedef struct packed {
    logic [7:0]   ctrl;
    logic [127:0] data;
  } ent_t;

  logic clk, rst;
  logic a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_ctrl, a_out_ctrl;
  logic [127:0] a_in_data, a_out_data;
  logic b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] b_in_ctrl, b_out_ctrl;
  logic [127:0] b_in_data, b_out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;
  logic [31:0] ma_stall, ma_flush, mb_stall, mb_flush;
`endif

  int checks = 0;
  int errors = 0;
  ent_t qa[$], qb[$];
  ent_t last_a, last_b;

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .SKID(1)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_ctrl(a_in_ctrl), .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_ctrl(a_out_ctrl), .out_data(a_out_data)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
`endif
  );

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .SKID(0)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_ctrl(b_in_ctrl), .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_ctrl(b_out_ctrl), .out_data(b_out_data)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
`endif
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    qa.delete();
    qb.delete();
    last_a = '0;
    last_b = '0;
`ifdef PIPE_STAGE_PERF_EN
    ma_stall = 0; ma_flush = 0; mb_stall = 0; mb_flush = 0;
`endif
  endtask

  // Called at a falling edge after inputs are set: check, advance across one rising edge.
  task automatic tick();
    bit upa, dna, upb, dnb;
    #1;
    chk("a_out_valid", 128'(a_out_valid), 128'(qa.size() > 0));
    chk("a_out_ctrl", 128'(a_out_ctrl), (qa.size() > 0) ? 128'(qa[0].ctrl) : 128'd0);
    chk("a_out_data", a_out_data, last_a.data);
    chk("a_in_ready", 128'(a_in_ready), 128'(qa.size() < 2));
    chk("b_out_valid", 128'(b_out_valid), 128'(qb.size() > 0));
    chk("b_out_ctrl", 128'(b_out_ctrl), (qb.size() > 0) ? 128'(qb[0].ctrl) : 128'd0);
    chk("b_out_data", b_out_data, last_b.data);
    chk("b_in_ready", 128'(b_in_ready), 128'(qb.size() == 0 || b_out_ready));
`ifdef PIPE_STAGE_PERF_EN
    chk("a_stall_cnt", 128'(a_stall_cnt), 128'(ma_stall));
    chk("a_flush_cnt", 128'(a_flush_cnt), 128'(ma_flush));
    chk("b_stall_cnt", 128'(b_stall_cnt), 128'(mb_stall));
    chk("b_flush_cnt", 128'(b_flush_cnt), 128'(mb_flush));
`endif
    upa = a_in_valid && (qa.size() < 2);
    dna = (qa.size() > 0) && a_out_ready;
    upb = b_in_valid && (qb.size() == 0 || b_out_ready);
    dnb = (qb.size() > 0) && b_out_ready;
`ifdef PIPE_STAGE_PERF_EN
    if (qa.size() > 0 && !a_out_ready) ma_stall++;
    if (qb.size() > 0 && !b_out_ready) mb_stall++;
    if (a_flush) ma_flush += qa.size() + int'(upa);
    if (b_flush) mb_flush += qb.size() + int'(upb);
`endif
    @(posedge clk);
    if (a_flush) qa.delete();
    else begin
      if (dna) void'(qa.pop_front());
      if (upa) qa.push_back('{ctrl: a_in_ctrl, data: a_in_data});
    end
    if (b_flush) qb.delete();
    else begin
      if (dnb) void'(qb.pop_front());
      if (upb) qb.push_back('{ctrl: b_in_ctrl, data: b_in_data});
    end
    if (qa.size() > 0) last_a = qa[0];
    if (qb.size() > 0) last_b = qb[0];
    @(negedge clk);
  endtask

  task automatic drive_a(input logic v, input logic [7:0] c, input logic [127:0] d, input logic ordy);
    a_in_valid = v; a_in_ctrl = c; a_in_data = d; a_out_ready = ordy;
  endtask

  task automatic drive_b(input logic v, input logic [7:0] c, input logic [127:0] d, input logic ordy);
    b_in_valid = v; b_in_ctrl = c; b_in_data = d; b_out_ready = ordy;
  endtask

  initial begin
    rst = 1'b0;
    a_flush = 0; b_flush = 0;
    drive_a(0, 8'h0, '0, 0);
    drive_b(0, 8'h0, '0, 0);
    model_clear();
    #2 rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_a_out_valid", 128'(a_out_valid), 128'd0);
    chk("rst_a_out_ctrl", 128'(a_out_ctrl), 128'd0);
    chk("rst_a_out_data", a_out_data, 128'd0);
    chk("rst_a_in_ready", 128'(a_in_ready), 128'd1);
    chk("rst_b_out_valid", 128'(b_out_valid), 128'd0);
    @(negedge clk);
    rst = 1'b0;

    // Streaming 1..8 into the skid stage, downstream always ready
    for (int i = 1; i <= 8; i++) begin
      drive_a(1, 8'(8'h10 + i), 128'(i), 1);
      tick();
    end
    drive_a(0, 8'h0, '0, 1);
    tick();
    tick();

    // Stall with skid: A accepted, B into skid, C refused until release
    drive_a(1, 8'h0A, 128'hA, 1); tick();
    drive_a(1, 8'h0B, 128'hB, 0); tick();
    drive_a(1, 8'h0C, 128'hC, 0); tick();
    chk("skid_head_A", a_out_data, 128'hA);
    chk("skid_full", 128'(a_in_ready), 128'd0);
    tick();
    drive_a(1, 8'h0C, 128'hC, 1); tick();
    chk("skid_head_B", a_out_data, 128'hB);
    tick();
    chk("skid_head_C", a_out_data, 128'hC);
    drive_a(0, 8'h0, '0, 1); tick();
    tick();

    // Flush while full (TWO) with a valid incoming entry
    drive_a(1, 8'h01, 128'h1111, 0); tick();
    drive_a(1, 8'h02, 128'h2222, 0); tick();
    drive_a(1, 8'hFF, 128'h3333, 0); a_flush = 1; tick();
    a_flush = 0;
    drive_a(0, 8'h0, '0, 0);
    chk("flush_out_valid", 128'(a_out_valid), 128'd0);
    chk("flush_out_ctrl", 128'(a_out_ctrl), 128'd0);
    chk("flush_in_ready", 128'(a_in_ready), 128'd1);
    tick();

    // Single-entry stage stalled for three cycles
    drive_b(1, 8'h5A, 128'hBEEF, 1); tick();
    drive_b(1, 8'h77, 128'hCAFE, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b_stall_data", b_out_data, 128'hBEEF);
      chk("b_stall_ready", 128'(b_in_ready), 128'd0);
    end
    drive_b(0, 8'h0, '0, 1); tick();
    tick();

    // Randomised traffic on both stages, occasional flush
    for (int i = 0; i < 400; i++) begin
      drive_a(1'($urandom_range(0, 3) != 0), 8'($urandom),
              {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 2) != 0));
      drive_b(1'($urandom_range(0, 3) != 0), 8'($urandom),
              {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 2) != 0));
      a_flush = ($urandom_range(0, 19) == 0);
      b_flush = ($urandom_range(0, 19) == 0);
      tick();
    end
    a_flush = 0; b_flush = 0;

    // Asynchronous reset between edges with both stages holding entries
    drive_a(1, 8'h33, 128'h44, 0); drive_b(1, 8'h55, 128'h66, 0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("arst_a_out_valid", 128'(a_out_valid), 128'd0);
    chk("arst_a_out_ctrl", 128'(a_out_ctrl), 128'd0);
    chk("arst_a_out_data", a_out_data, 128'd0);
    chk("arst_b_out_valid", 128'(b_out_valid), 128'd0);
    chk("arst_b_out_data", b_out_data, 128'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    drive_a(0, 8'h0, '0, 1); drive_b(0, 8'h0, '0, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
